// File: rtl/inst_prefetch_queue_if.sv
// Bundle between the prefetch queue, instruction memory, redirect source and fetch stage.
// master: the prefetch queue; slave: its environment (memory, back end, fetch stage).
interface inst_prefetch_queue_if;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_ready;

  modport master (
    output mem_req, mem_addr, out_valid, out_instr, out_pc,
    input  mem_ack, mem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_instr, out_pc,
    output mem_ack, mem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: one outstanding memory read at a time, FWFT output queue,
// and redirect handling that flushes the queue and drops any in-flight response.
module inst_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  inst_prefetch_queue_if.master bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   cnt_t;

  localparam cnt_t FullCount = cnt_t'(DEPTH);
  localparam cnt_t CntOne    = cnt_t'(1);
  localparam ptr_t PtrOne    = ptr_t'(1);

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e      state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [63:0] req_addr_q, req_addr_d;
  ptr_t        head_q, tail_q;
  cnt_t        count_q;
  logic [31:0] instr_mem [DEPTH];
  logic [63:0] pc_mem    [DEPTH];

  logic can_issue;
  logic push;
  logic pop;

  // Reset gates the request combinationally so mem_req is low for the whole reset window.
  assign can_issue = (state_q == StIdle) && (count_q != FullCount) && !bus.redirect && !reset;

  assign bus.mem_req   = can_issue || (state_q != StIdle);
  assign bus.mem_addr  = (state_q == StIdle) ? fetch_pc_q : req_addr_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_instr = instr_mem[head_q];
  assign bus.out_pc    = pc_mem[head_q];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    pop        = bus.out_valid && bus.out_ready && !bus.redirect;

    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StWait:  state_d = bus.mem_ack ? StIdle : StDrop;
        StDrop:  state_d = bus.mem_ack ? StIdle : StDrop;
        default: state_d = StIdle;
      endcase
    end else begin
      unique case (state_q)
        StIdle: begin
          if (can_issue) begin
            req_addr_d = fetch_pc_q;
            state_d    = StWait;
          end
        end
        StWait: begin
          if (bus.mem_ack) begin
            push       = 1'b1;
            fetch_pc_d = req_addr_q + 64'd4;
            state_d    = StIdle;
          end
        end
        StDrop: begin
          if (bus.mem_ack) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (bus.redirect) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tail_q <= tail_q + PtrOne;
      end
      if (pop) begin
        head_q <= head_q + PtrOne;
      end
      if (push && !pop) begin
        count_q <= count_q + CntOne;
      end else if (pop && !push) begin
        count_q <= count_q - CntOne;
      end
    end
  end

  // Payload storage needs no reset; out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_q] <= bus.mem_rdata;
      pc_mem[tail_q]    <= req_addr_q;
    end
  end

endmodule
